// File: rtl/ring_nic_if.sv
// Processor bus and router PE port of the ring NIC, bundled as one interface.
// master = processor/router environment, slave = the NIC.
interface ring_nic_if #(
  parameter int DATA_WIDTH = 64
);
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  nicEn;
  logic                  nicEnWr;

  // Router handshakes: a packet moves on a posedge where its valid (pesi/peso)
  // and the receiver's ready (peri/pero) are both high; data (pedi/pedo) is only
  // meaningful while valid is high, and the sender holds it until that edge.
  logic                  pesi;
  logic                  peri;
  logic [DATA_WIDTH-1:0] pedi;
  logic                  peso;
  logic                  pero;
  logic [DATA_WIDTH-1:0] pedo;
  logic                  polarity;

  modport master (
    output addr, d_in, nicEn, nicEnWr, peri, peso, pedo, polarity,
    input  d_out, pesi, pedi, pero
  );

  modport slave (
    input  addr, d_in, nicEn, nicEnWr, peri, peso, pedo, polarity,
    output d_out, pesi, pedi, pero
  );
endinterface

// File: rtl/ring_nic.sv
// Ring NIC: one outgoing and one incoming packet buffer behind a 2-bit register map.
// Optional NIC_STATS_EN adds saturating rx/tx counters reported in status reads.
module ring_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 63,
  parameter int CNT_WIDTH  = 8
) (
  input  logic      clk,
  input  logic      reset,
  ring_nic_if.slave nic
);
  logic [DATA_WIDTH-1:0] r_out_buf;
  logic                  r_out_full;
  logic [DATA_WIDTH-1:0] r_in_buf;
  logic                  r_in_full;
  logic [DATA_WIDTH-1:0] r_d_out;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_pesi;
  logic                  w_pero;
  logic                  w_rx;
  logic [DATA_WIDTH-1:0] w_in_status;
  logic [DATA_WIDTH-1:0] w_out_status;

  assign w_rd = nic.nicEn & ~nic.nicEnWr;
  assign w_wr = nic.nicEn & nic.nicEnWr;

  // A packet may only leave on the phase opposite to its VC bit.
  assign w_pesi = r_out_full & nic.peri & (nic.polarity == ~r_out_buf[VC_BIT]) & ~reset;
  assign w_pero = ~r_in_full & ~reset;
  assign w_rx   = nic.peso & w_pero;

  assign nic.pesi  = w_pesi;
  assign nic.pedi  = w_pesi ? r_out_buf : '0;
  assign nic.pero  = w_pero;
  assign nic.d_out = r_d_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else if (w_pesi) begin
      r_out_full <= 1'b0;
    end else if (w_wr && nic.addr == 2'b10 && !r_out_full) begin
      r_out_buf  <= nic.d_in;
      r_out_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else if (w_rx) begin
      r_in_buf  <= nic.pedo;
      r_in_full <= 1'b1;
    end else if (w_rd && nic.addr == 2'b00 && r_in_full) begin
      r_in_full <= 1'b0;
    end
  end

`ifdef NIC_STATS_EN
  logic [CNT_WIDTH-1:0] r_rx_cnt;
  logic [CNT_WIDTH-1:0] r_tx_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_cnt <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_rx && r_rx_cnt != '1)
        r_rx_cnt <= r_rx_cnt + CNT_WIDTH'(1);
      if (w_pesi && r_tx_cnt != '1)
        r_tx_cnt <= r_tx_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_in_status                  = '0;
    w_out_status                 = '0;
    w_in_status[0]               = r_in_full;
    w_out_status[0]              = r_out_full;
    w_in_status[8 +: CNT_WIDTH]  = r_rx_cnt;
    w_out_status[8 +: CNT_WIDTH] = r_tx_cnt;
  end
`else
  always_comb begin
    w_in_status     = '0;
    w_out_status    = '0;
    w_in_status[0]  = r_in_full;
    w_out_status[0] = r_out_full;
  end
`endif

  // Read data is registered; status reflects flags before this edge's updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_out <= '0;
    end else if (w_rd) begin
      case (nic.addr)
        2'b00:   r_d_out <= r_in_buf;
        2'b01:   r_d_out <= w_in_status;
        2'b10:   r_d_out <= '0;
        default: r_d_out <= w_out_status;
      endcase
    end
  end
endmodule

// File: tb/tb_ring_nic.sv
// Directed self-checking bench for ring_nic; stats checks run when NIC_STATS_EN is defined.
module tb_ring_nic;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   exp_rx;
  int   exp_tx;
  logic [63:0] rd_val;

  ring_nic_if #(.DATA_WIDTH(64)) nic ();

  ring_nic #(.DATA_WIDTH(64), .VC_BIT(63), .CNT_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .nic   (nic)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] stat(input logic flag, input int cnt);
    logic [63:0] v;
    v    = '0;
    v[0] = flag;
`ifdef NIC_STATS_EN
    v[15:8] = cnt[7:0];
`endif
    return v;
  endfunction

  // driver tasks; polarity toggles once per clock
  task automatic tick();
    @(posedge clk);
    #1;
    nic.polarity = ~nic.polarity;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [63:0] d);
    nic.nicEn   = 1'b1;
    nic.nicEnWr = 1'b1;
    nic.addr    = a;
    nic.d_in    = d;
    tick();
    nic.nicEn   = 1'b0;
    nic.nicEnWr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [63:0] d);
    nic.nicEn   = 1'b1;
    nic.nicEnWr = 1'b0;
    nic.addr    = a;
    tick();
    nic.nicEn   = 1'b0;
    d           = nic.d_out;
  endtask

  // Expects a queued packet with peri=1 to go out on the first matching phase.
  task automatic send_wait(input logic [63:0] pkt);
    logic exp_s;
    logic sent;
    sent = 1'b0;
    for (int i = 0; i < 3 && !sent; i++) begin
      @(negedge clk);
      exp_s = (nic.polarity == ~pkt[63]);
      check("send_pesi", {63'd0, nic.pesi}, {63'd0, exp_s});
      check("send_pedi", nic.pedi, exp_s ? pkt : 64'd0);
      tick();
      if (exp_s) begin
        sent = 1'b1;
        exp_tx = (exp_tx < 255) ? exp_tx + 1 : 255;
      end
    end
    if (!sent) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic recv(input logic [63:0] pkt);
    @(negedge clk);
    check("recv_pero", {63'd0, nic.pero}, 64'd1);
    nic.peso = 1'b1;
    nic.pedo = pkt;
    tick();
    nic.peso = 1'b0;
    exp_rx = (exp_rx < 255) ? exp_rx + 1 : 255;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_rx   = 0;
    exp_tx   = 0;
    reset        = 1'b1;
    nic.addr     = 2'b00;
    nic.d_in     = '0;
    nic.nicEn    = 1'b0;
    nic.nicEnWr  = 1'b0;
    nic.peri     = 1'b0;
    nic.peso     = 1'b0;
    nic.pedo     = '0;
    nic.polarity = 1'b0;

    // 1: reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_pesi", {63'd0, nic.pesi}, 64'd0);
    check("rst_pero", {63'd0, nic.pero}, 64'd0);
    check("rst_dout", nic.d_out, 64'd0);
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("rel_pero", {63'd0, nic.pero}, 64'd1);
    cpu_rd(2'b01, rd_val);
    check("rel_in_status", rd_val, 64'd0);
    cpu_rd(2'b11, rd_val);
    check("rel_out_status", rd_val, 64'd0);

    // 2: VC=0 packet leaves only on polarity=1
    nic.peri = 1'b1;
    cpu_wr(2'b10, 64'h4000_0100_0000_0000);
    send_wait(64'h4000_0100_0000_0000);
    @(negedge clk);
    check("t2_pesi_after", {63'd0, nic.pesi}, 64'd0);
    cpu_rd(2'b11, rd_val);
    check("t2_out_status", rd_val, stat(1'b0, exp_tx));

    // 3: VC=1 packet held while peri=0, overwrite dropped, sent on polarity=0
    nic.peri = 1'b0;
    cpu_wr(2'b10, 64'h8000_0000_0000_00A5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_pesi", {63'd0, nic.pesi}, 64'd0);
      check("t3_hold_pedi", nic.pedi, 64'd0);
      tick();
    end
    cpu_rd(2'b11, rd_val);
    check("t3_out_status", rd_val, stat(1'b1, exp_tx));
    cpu_wr(2'b10, 64'h8000_0000_0000_0BAD);
    nic.peri = 1'b1;
    send_wait(64'h8000_0000_0000_00A5);
    cpu_rd(2'b11, rd_val);
    check("t3_out_status_after", rd_val, stat(1'b0, exp_tx));

    // 4: receive, second delivery ignored, consuming read
    recv(64'h0000_0001_0000_0000);
    @(negedge clk);
    check("t4_pero_full", {63'd0, nic.pero}, 64'd0);
    cpu_rd(2'b01, rd_val);
    check("t4_in_status", rd_val, stat(1'b1, exp_rx));
    nic.peso = 1'b1;
    nic.pedo = 64'hDEAD_BEEF_0000_0001;
    tick();
    nic.peso = 1'b0;
    cpu_rd(2'b00, rd_val);
    check("t4_in_buf", rd_val, 64'h0000_0001_0000_0000);
    @(negedge clk);
    check("t4_pero_empty", {63'd0, nic.pero}, 64'd1);
    cpu_rd(2'b01, rd_val);
    check("t4_in_status_after", rd_val, stat(1'b0, exp_rx));
    cpu_rd(2'b00, rd_val);
    check("t4_stale_read", rd_val, 64'h0000_0001_0000_0000);
    cpu_rd(2'b10, rd_val);
    check("t4_out_buf_read", rd_val, 64'd0);

    // 5: reset with both buffers full
    nic.peri = 1'b0;
    cpu_wr(2'b10, 64'h0000_0000_0000_0055);
    recv(64'h0000_0000_0000_1234);
    reset    = 1'b1;
    nic.peri = 1'b1;
    @(negedge clk);
    check("t5_rst_pesi", {63'd0, nic.pesi}, 64'd0);
    check("t5_rst_pedi", nic.pedi, 64'd0);
    check("t5_rst_pero", {63'd0, nic.pero}, 64'd0);
    tick();
    reset  = 1'b0;
    exp_rx = 0;
    exp_tx = 0;
    @(negedge clk);
    check("t5_fall_pesi", {63'd0, nic.pesi}, 64'd0);
    check("t5_fall_pedi", nic.pedi, 64'd0);
    check("t5_fall_pero", {63'd0, nic.pero}, 64'd1);
    check("t5_fall_dout", nic.d_out, 64'd0);
    cpu_rd(2'b01, rd_val);
    check("t5_in_status", rd_val, 64'd0);
    cpu_rd(2'b11, rd_val);
    check("t5_out_status", rd_val, 64'd0);

`ifdef NIC_STATS_EN
    // 6: counters, then rx saturation
    for (int i = 0; i < 3; i++) begin
      cpu_wr(2'b10, 64'h0000_0000_0000_0100 + 64'(i));
      send_wait(64'h0000_0000_0000_0100 + 64'(i));
    end
    for (int i = 0; i < 2; i++) begin
      recv(64'h0000_0000_0000_0200 + 64'(i));
      cpu_rd(2'b00, rd_val);
    end
    cpu_rd(2'b11, rd_val);
    check("t6_tx_cnt", rd_val, 64'h300);
    cpu_rd(2'b01, rd_val);
    check("t6_rx_cnt", rd_val, 64'h200);
    for (int i = 0; i < 300; i++) begin
      nic.peso = 1'b1;
      nic.pedo = 64'(i);
      tick();
      nic.peso = 1'b0;
      cpu_rd(2'b00, rd_val);
    end
    cpu_rd(2'b01, rd_val);
    check("t6_rx_sat", rd_val, 64'hFF00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
